// File: rtl/two_entry_output_buffer.sv
// ============================================================================
// Module   : two_entry_output_buffer
// Purpose  : Head/tail skid buffer presenting a registered valid/data stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module two_entry_output_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  occ_t             r_state;
  occ_t             w_state_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_cons;
  logic             w_head_load;
  logic             w_head_from_tail;
  logic             w_tail_load;

  assign w_cons = (r_state != S_EMPTY) && i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Push at occupancy TWO is never issued by the wrapper, so it is ignored here.
  always_comb begin
    w_state_nxt      = r_state;
    w_head_load      = 1'b0;
    w_head_from_tail = 1'b0;
    w_tail_load      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (i_push) begin
          w_head_load = 1'b1;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (i_push && w_cons) begin
          w_head_load = 1'b1;
        end else if (i_push) begin
          w_tail_load = 1'b1;
          w_state_nxt = S_TWO;
        end else if (w_cons) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_cons) begin
          w_head_from_tail = 1'b1;
          w_state_nxt      = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_head_load) begin
      r_head <= i_push_data;
    end else if (w_head_from_tail) begin
      r_head <= r_tail;
    end
    if (w_tail_load) begin
      r_tail <= i_push_data;
    end
  end

  assign o_valid     = (r_state != S_EMPTY);
  assign o_data      = r_head;
  assign o_occupancy = r_state;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a show-ahead FIFO into a registered valid/ready stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_pop,
  output logic             down_valid,
  output logic [WIDTH-1:0] down_data,
  input  logic             down_ready,
  output logic [1:0]       occupancy,
  output logic             idle
);

  logic [1:0] w_occ;
  logic       w_pop;

  // Pop depends only on the FIFO flag and local occupancy, never on down_ready.
  assign w_pop = !fifo_empty && (w_occ < 2'd2);

  two_entry_output_buffer #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_pop),
    .i_push_data (fifo_read_data),
    .o_valid     (down_valid),
    .o_data      (down_data),
    .i_ready     (down_ready),
    .o_occupancy (w_occ)
  );

  assign fifo_pop  = w_pop;
  assign occupancy = w_occ;
  assign idle      = fifo_empty && (w_occ == 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench: queue-based FIFO and output reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_read_data;
  logic       fifo_pop;
  logic       down_valid;
  logic [7:0] down_data;
  logic       down_ready;
  logic [1:0] occupancy;
  logic       idle;

  fifo_stream_reader #(.WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_pop       (fifo_pop),
    .down_valid     (down_valid),
    .down_data      (down_data),
    .down_ready     (down_ready),
    .occupancy      (occupancy),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       push_en;
    logic [7:0] push_d;
    logic       e_pop;
    logic [1:0] e_occ;
    logic       e_valid;
    logic [7:0] e_data;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO contents, words popped but not yet delivered, and stream logs.
  logic [7:0] q[$];
  logic [7:0] held[$];
  logic [7:0] sent[$];
  logic [7:0] recv[$];

  logic       s_pop;
  logic       s_cons;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  vec_t bp_tab[8];
  vec_t h1_tab[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    q.push_back(w);
    sent.push_back(w);
  endtask

  // Called at a falling edge: drive inputs, then compare against the model.
  task automatic drive_and_check(input logic rdy, input logic gap);
    int exp_occ;
    logic exp_pop;
    down_ready     = rdy;
    fifo_empty     = gap || (q.size() == 0);
    fifo_read_data = (q.size() != 0) ? q[0] : 8'($urandom);
    #1;
    exp_occ = held.size();
    exp_pop = !fifo_empty && (exp_occ < 2);
    chk("occupancy", int'(occupancy), exp_occ);
    chk("down_valid", int'(down_valid), int'(exp_occ != 0));
    chk("fifo_pop", int'(fifo_pop), int'(exp_pop));
    chk("idle", int'(idle), int'(fifo_empty && exp_occ == 0));
    if (fifo_empty) chk("pop_while_empty", int'(fifo_pop), 0);
    if (exp_occ != 0) chk("down_data", int'(down_data), int'(held[0]));
    if (hold_v) begin
      chk("stall_valid_stable", int'(down_valid), 1);
      chk("stall_data_stable", int'(down_data), int'(hold_d));
    end
    s_pop  = exp_pop;
    s_cons = (exp_occ != 0) && rdy;
  endtask

  task automatic advance();
    hold_v = (held.size() != 0) && !down_ready;
    hold_d = (held.size() != 0) ? held[0] : 8'h00;
    @(posedge clk);
    if (s_cons) recv.push_back(held.pop_front());
    if (s_pop)  held.push_back(q.pop_front());
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    if (v.push_en) push_word(v.push_d);
    drive_and_check(v.rdy, 1'b0);
    chk({tag, "_pop"}, int'(fifo_pop), int'(v.e_pop));
    chk({tag, "_occ"}, int'(occupancy), int'(v.e_occ));
    chk({tag, "_valid"}, int'(down_valid), int'(v.e_valid));
    if (v.e_valid) chk({tag, "_data"}, int'(down_data), int'(v.e_data));
    advance();
  endtask

  task automatic compare_stream(input string nm);
    int n;
    chk({nm, "_count"}, recv.size(), sent.size());
    n = (recv.size() < sent.size()) ? recv.size() : sent.size();
    for (int i = 0; i < n; i++) chk({nm, "_order"}, int'(recv[i]), int'(sent[i]));
    recv.delete();
    sent.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int pushed;
    int cyc;

    // rdy push_en push_d  pop occ valid data
    bp_tab[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00};
    bp_tab[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h11};
    bp_tab[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 8'h11};
    bp_tab[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 8'h11};
    bp_tab[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 8'h11};
    bp_tab[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h22};
    bp_tab[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 8'h33};
    bp_tab[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};

    h1_tab[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00};
    h1_tab[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 8'h5A};
    h1_tab[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 2'd1, 1'b1, 8'h5A};
    h1_tab[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 8'h5A};
    h1_tab[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 8'h5A};
    h1_tab[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 8'hA5};
    h1_tab[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};

    rst            = 1'b1;
    fifo_empty     = 1'b1;
    fifo_read_data = 8'h00;
    down_ready     = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_occupancy", int'(occupancy), 0);
    chk("reset_valid", int'(down_valid), 0);
    chk("reset_idle", int'(idle), 1);
    chk("reset_pop", int'(fifo_pop), 0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming: ten preloaded words at full rate.
    for (int i = 1; i <= 10; i++) push_word(8'(i));
    drive_and_check(1'b1, 1'b0);
    chk("stream_first_pop", int'(fifo_pop), 1);
    advance();
    for (int i = 1; i <= 10; i++) begin
      drive_and_check(1'b1, 1'b0);
      chk("stream_valid", int'(down_valid), 1);
      chk("stream_data", int'(down_data), i);
      advance();
    end
    drive_and_check(1'b1, 1'b0);
    chk("stream_idle", int'(idle), 1);
    advance();
    compare_stream("stream");

    // Backpressure with three words.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    foreach (bp_tab[i]) apply_vec(bp_tab[i], "bp");
    compare_stream("bp");

    // Occupancy-1 hold while a second word arrives.
    push_word(8'h5A);
    foreach (h1_tab[i]) apply_vec(h1_tab[i], "hold1");
    compare_stream("hold1");

    // FIFO alternately visible / hidden with ready held high.
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    for (int c = 0; c < 40; c++) begin
      drive_and_check(1'b1, c[0]);
      chk("gap_occ_le1", int'(occupancy <= 2'd1), 1);
      advance();
    end
    compare_stream("gaps");

    // Random arrivals and random ready.
    pushed = 0;
    cyc    = 0;
    while (recv.size() < 200 && cyc < 3000) begin
      if (pushed < 200 && $urandom_range(0, 3) != 0) begin
        push_word(8'($urandom));
        pushed++;
      end
      drive_and_check(1'($urandom_range(0, 1)), 1'b0);
      advance();
      cyc++;
    end
    if (recv.size() < 200) chk("random_timeout", recv.size(), 200);
    compare_stream("random");

    // Asynchronous reset mid-cycle with two words buffered.
    push_word(8'hC1);
    push_word(8'hC2);
    for (int i = 0; i < 3; i++) begin
      drive_and_check(1'b0, 1'b0);
      advance();
    end
    drive_and_check(1'b0, 1'b0);
    chk("pre_rst_occ", int'(occupancy), 2);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", int'(down_valid), 0);
    chk("rst_mid_occ", int'(occupancy), 0);
    q.delete();
    held.delete();
    recv.delete();
    sent.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_and_check(1'b1, 1'b0);
    chk("post_rst_idle", int'(idle), 1);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
